// File: rtl/seq_ctrl_pkg.sv
// Shared types and encoding constants for the 8-bit core sequencer.
// Optional stack ops are enabled with SEQ_STACK_EN (see seq_decode / seq_ctrl).
package seq_ctrl_pkg;

    typedef enum logic [2:0] {S_FETCH, S_FETCH_IMM, S_EXEC, S_MEM, S_HALT} e_seq_state;
    typedef enum logic [1:0] {REG_A, REG_B, REG_C, REG_D} e_reg;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_CPY} e_alu_op;
    typedef enum logic [1:0] {ALU_EX_NONE, ALU_EX_SP_DEC, ALU_EX_SP_INC} e_alu_ext_op;

    typedef logic [3:0] e_opcode;
    localparam e_opcode OPC_NOP        = 4'h0;
    localparam e_opcode OPC_ALU_FIRST  = 4'h1;
    localparam e_opcode OPC_ALU_LAST   = 4'h6;
    localparam e_opcode OPC_MEM        = 4'h7;
    localparam e_opcode OPC_ALUI_FIRST = 4'h9;
    localparam e_opcode OPC_ALUI_LAST  = 4'hE;
    localparam e_opcode OPC_CTL        = 4'hF;

    localparam int OP_HI = 7, OP_LO = 4, RD_HI = 3, RD_LO = 2, RS_HI = 1, RS_LO = 0;

    localparam logic [1:0] BR_JMP   = 2'd0, BR_BEQ = 2'd1, BR_BNE  = 2'd2, BR_HALT = 2'd3;
    localparam logic [1:0] MEM_LD   = 2'd0, MEM_ST = 2'd1, MEM_PUSH = 2'd2, MEM_POP = 2'd3;

    // Reg-reg (1..6) and immediate (9..E) ALU ops share the low three opcode bits.
    function automatic e_alu_op alu_of(input e_opcode op);
        return e_alu_op'(op[2:0] - 3'd1);
    endfunction

endpackage

// File: rtl/seq_ctrl_if.sv
// Instruction- and data-memory handshake bundle between the sequencer and the memories.
interface seq_ctrl_if;
    logic       imem_req;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic       imem_sel;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ack;

    modport master (output imem_req, imem_sel, dmem_req, dmem_we,
                    input  imem_ack, imem_data, dmem_ack);
    modport slave  (input  imem_req, imem_sel, dmem_req, dmem_we,
                    output imem_ack, imem_data, dmem_ack);
endinterface

// File: rtl/seq_ctrl_decode.sv
// Combinational opcode decoder. PUSH/POP are only legal when SEQ_STACK_EN is defined;
// otherwise op 7 with rs=1x decodes as illegal.
module seq_decode
    import seq_ctrl_pkg::*;
(
    input  logic [7:0] instr,
    output logic       needs_imm,
    output logic       is_mem,
    output logic       is_branch,
    output logic       is_alu,
    output logic       is_halt,
    output logic       legal,
    output e_alu_op    alu_op,
    output e_reg       rd,
    output e_reg       rs
);
    e_opcode    op;
    logic [1:0] sub;

    assign op  = instr[OP_HI:OP_LO];
    assign sub = instr[RS_HI:RS_LO];
    assign rd  = e_reg'(instr[RD_HI:RD_LO]);
    assign rs  = e_reg'(sub);

    always_comb begin
        needs_imm = 1'b0;
        is_mem    = 1'b0;
        is_branch = 1'b0;
        is_alu    = 1'b0;
        is_halt   = 1'b0;
        legal     = 1'b1;
        alu_op    = ALU_ADD;
        if (op inside {[OPC_ALU_FIRST:OPC_ALU_LAST]}) begin
            is_alu = 1'b1;
            alu_op = alu_of(op);
        end else if (op inside {[OPC_ALUI_FIRST:OPC_ALUI_LAST]}) begin
            is_alu    = 1'b1;
            needs_imm = 1'b1;
            alu_op    = alu_of(op);
        end else begin
            case (op)
                OPC_NOP: ;
                OPC_MEM: begin
                    if (sub == MEM_LD || sub == MEM_ST) begin
                        is_mem    = 1'b1;
                        needs_imm = 1'b1;
                    end else begin
`ifdef SEQ_STACK_EN
                        is_mem = 1'b1;
`else
                        legal  = 1'b0;
`endif
                    end
                end
                OPC_CTL: begin
                    if (sub == BR_HALT) begin
                        is_halt = 1'b1;
                    end else begin
                        is_branch = 1'b1;
                        needs_imm = 1'b1;
                        alu_op    = ALU_CPY;
                    end
                end
                default: legal = 1'b0;  // op 8 is the only code left
            endcase
        end
    end
endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer with imem/dmem handshakes and a wait watchdog.
// Define SEQ_STACK_EN to execute PUSH/POP; otherwise they retire as illegal NOPs.
module seq_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    seq_ctrl_if.master  bus,
    output e_reg        rd,
    output e_reg        rs,
    output logic [7:0]  imm,
    output e_alu_op     alu_op,
    output e_alu_ext_op alu_ex,
    output logic        alu_src,
    output logic        reg_wr,
    output logic        mem_to_reg,
    output logic        pc_src,
    output logic        rimm,
    output logic        sp_wr,
    output logic        mem_sp,
    output logic        pc_en,
    input  logic        alu_zero,
    output logic        halted,
    output logic        illegal,
    output logic        bus_err
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    e_seq_state    state;
    logic [7:0]    instr;
    logic [7:0]    imm_q;
    logic [CW-1:0] cnt;

    logic       d_needs_imm, d_is_mem, d_is_branch, d_is_alu, d_is_halt, d_legal;
    e_alu_op    d_alu_op;
    e_reg       d_rd, d_rs;
    logic [7:0] dec_in;
    logic [1:0] sub;
    logic       stack_op;
    logic       timeout;

    // In S_FETCH the next-state choice needs the byte arriving on the bus, not the stale latch.
    assign dec_in   = (state == S_FETCH) ? bus.imem_data : instr;
    assign sub      = instr[RS_HI:RS_LO];
    assign stack_op = d_is_mem && !d_needs_imm;
    assign timeout  = (TIMEOUT != 0) && (cnt == CNT_LAST);

    seq_decode u_dec (
        .instr     (dec_in),
        .needs_imm (d_needs_imm),
        .is_mem    (d_is_mem),
        .is_branch (d_is_branch),
        .is_alu    (d_is_alu),
        .is_halt   (d_is_halt),
        .legal     (d_legal),
        .alu_op    (d_alu_op),
        .rd        (d_rd),
        .rs        (d_rs)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            cnt   <= '0;
            instr <= '0;
            imm_q <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            case (state)
                S_FETCH: begin
                    if (bus.imem_ack) begin
                        instr <= bus.imem_data;
                        cnt   <= '0;
                        state <= d_needs_imm ? S_FETCH_IMM : (d_is_mem ? S_MEM : S_EXEC);
                    end else if (timeout) begin
                        cnt <= '0;
                    end
                end
                S_FETCH_IMM: begin
                    if (bus.imem_ack) begin
                        imm_q <= bus.imem_data;
                        cnt   <= '0;
                        state <= d_is_mem ? S_MEM : S_EXEC;
                    end else if (timeout) begin
                        cnt   <= '0;
                        state <= S_FETCH;
                    end
                end
                S_EXEC: begin
                    cnt   <= '0;
                    state <= d_is_halt ? S_HALT : S_FETCH;
                end
                S_MEM: begin
                    if (bus.dmem_ack || timeout) begin
                        cnt   <= '0;
                        state <= S_FETCH;
                    end
                end
                S_HALT:  cnt <= '0;
                default: begin
                    cnt   <= '0;
                    state <= S_FETCH;
                end
            endcase
        end
    end

    always_comb begin
        bus.imem_req = 1'b0;
        bus.imem_sel = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        rd           = REG_A;
        rs           = REG_A;
        imm          = '0;
        alu_op       = ALU_ADD;
        alu_ex       = ALU_EX_NONE;
        alu_src      = 1'b0;
        reg_wr       = 1'b0;
        mem_to_reg   = 1'b0;
        pc_src       = 1'b0;
        rimm         = 1'b0;
        sp_wr        = 1'b0;
        mem_sp       = 1'b0;
        pc_en        = 1'b0;
        halted       = 1'b0;
        illegal      = 1'b0;
        bus_err      = 1'b0;
        if (!rst) begin
            rd  = d_rd;
            rs  = d_rs;
            imm = imm_q;
            case (state)
                S_FETCH: begin
                    bus.imem_req = 1'b1;
                    if (!bus.imem_ack && timeout) begin
                        bus_err = 1'b1;
                        pc_en   = 1'b1;
                    end
                end
                S_FETCH_IMM: begin
                    bus.imem_req = 1'b1;
                    bus.imem_sel = 1'b1;
                    if (!bus.imem_ack && timeout) begin
                        bus_err = 1'b1;
                        pc_en   = 1'b1;
                        rimm    = 1'b1;
                    end
                end
                S_EXEC: begin
                    if (!d_is_halt) begin
                        pc_en   = 1'b1;
                        rimm    = d_needs_imm;
                        illegal = !d_legal;
                        alu_op  = d_alu_op;
                        if (d_is_alu) begin
                            reg_wr  = 1'b1;
                            alu_src = d_needs_imm;
                        end
                        if (d_is_branch)
                            pc_src = (sub == BR_JMP) || (sub == BR_BEQ && alu_zero)
                                   || (sub == BR_BNE && !alu_zero);
                    end
                end
                S_MEM: begin
                    bus.dmem_req = 1'b1;
                    bus.dmem_we  = (sub == MEM_ST) || (sub == MEM_PUSH);
                    if (stack_op)
                        alu_ex = (sub == MEM_PUSH) ? ALU_EX_SP_DEC : ALU_EX_SP_INC;
                    if (bus.dmem_ack) begin
                        pc_en      = 1'b1;
                        rimm       = d_needs_imm;
                        reg_wr     = (sub == MEM_LD) || (sub == MEM_POP);
                        mem_to_reg = (sub == MEM_LD) || (sub == MEM_POP);
                        sp_wr      = stack_op;
                        mem_sp     = (sub == MEM_POP);
                    end else if (timeout) begin
                        bus_err = 1'b1;
                        pc_en   = 1'b1;
                        rimm    = d_needs_imm;
                    end
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_ctrl.sv
// Directed-vector bench for seq_ctrl: one task per scenario, hand-computed control words.
module tb_seq_ctrl;
    import seq_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_zero = 1'b0;
    e_reg        rd, rs;
    logic [7:0]  imm;
    e_alu_op     alu_op;
    e_alu_ext_op alu_ex;
    logic        alu_src, reg_wr, mem_to_reg, pc_src, rimm, sp_wr, mem_sp, pc_en;
    logic        halted, illegal, bus_err;
    int          vectors = 0;
    int          miscompares = 0;
    logic [14:0] ctl, e;

    localparam logic [14:0] IREQ = 15'h4000, ISEL = 15'h2000, DREQ = 15'h1000, DWE  = 15'h0800,
                            RWR  = 15'h0400, M2R  = 15'h0200, ASRC = 15'h0100, PSRC = 15'h0080,
                            RIMM = 15'h0040, PCEN = 15'h0020, SPWR = 15'h0010, MSP  = 15'h0008,
                            HLT  = 15'h0004, ILL  = 15'h0002, BERR = 15'h0001;

    seq_ctrl_if bus ();

    seq_ctrl #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .bus(bus), .rd(rd), .rs(rs), .imm(imm), .alu_op(alu_op),
        .alu_ex(alu_ex), .alu_src(alu_src), .reg_wr(reg_wr), .mem_to_reg(mem_to_reg),
        .pc_src(pc_src), .rimm(rimm), .sp_wr(sp_wr), .mem_sp(mem_sp), .pc_en(pc_en),
        .alu_zero(alu_zero), .halted(halted), .illegal(illegal), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    assign ctl = {bus.imem_req, bus.imem_sel, bus.dmem_req, bus.dmem_we, reg_wr, mem_to_reg,
                  alu_src, pc_src, rimm, pc_en, sp_wr, mem_sp, halted, illegal, bus_err};

    // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the rising edge.
    task automatic step(input logic r, input logic ia, input logic [7:0] id,
                        input logic da, input logic z);
        @(negedge clk);
        rst           = r;
        bus.imem_ack  = ia;
        bus.imem_data = id;
        bus.dmem_ack  = da;
        alu_zero      = z;
        #1;
    endtask

    task automatic test_reset();
        step(1, 1, 8'hFF, 1, 1); e = '0;
        vectors++; if (ctl !== e) begin miscompares++; $display("FAIL rst_c0 ctl=%h exp=%h", ctl, e); end
        vectors++;
        if ({rd, rs, imm, alu_op, alu_ex} !== 17'd0) begin
            miscompares++; $display("FAIL rst_fields got=%h exp=0", {rd, rs, imm, alu_op, alu_ex});
        end
        step(1, 0, 8'h00, 0, 0);
        vectors++; if (ctl !== e) begin miscompares++; $display("FAIL rst_c1 ctl=%h exp=%h", ctl, e); end
    endtask

    task automatic test_reg_reg();
        step(0, 1, 8'h16, 0, 0); e = IREQ;
        vectors++; if (ctl !== e) begin miscompares++; $display("FAIL rr_fetch ctl=%h exp=%h", ctl, e); end
        step(0, 0, 8'h00, 0, 0); e = RWR | PCEN;
        vectors++; if (ctl !== e) begin miscompares++; $display("FAIL rr_exec ctl=%h exp=%h", ctl, e); end
        vectors++;
        if ({rd, rs, alu_op} !== 7'b01_10_000) begin
            miscompares++; $display("FAIL rr_fields got=%b exp=0110000", {rd, rs, alu_op});
        end
        step(0, 1, 8'h5B, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        vectors++;
        if ({rd, rs, alu_op} !== 7'b10_11_100) begin
            miscompares++; $display("FAIL xor_fields got=%b exp=1011100", {rd, rs, alu_op});
        end
    endtask

    task automatic test_imm_alu();
        step(0, 1, 8'h94, 0, 0); e = IREQ;
        vectors++; if (ctl !== e) begin miscompares++; $display("FAIL ai_fetch ctl=%h exp=%h", ctl, e); end
        step(0, 1, 8'h05, 0, 0); e = IREQ | ISEL;
        vectors++; if (ctl !== e) begin miscompares++; $display("FAIL ai_fetch_imm ctl=%h exp=%h", ctl, e); end
        step(0, 0, 8'h00, 0, 0); e = RWR | ASRC | RIMM | PCEN;
        vectors++; if (ctl !== e) begin miscompares++; $display("FAIL ai_exec ctl=%h exp=%h", ctl, e); end
        vectors++;
        if ({imm, rd, alu_op} !== {8'h05, 2'b01, 3'd0}) begin
            miscompares++; $display("FAIL ai_fields got=%h exp=%h", {imm, rd, alu_op}, {8'h05, 2'b01, 3'd0});
        end
    endtask

    task automatic test_branch();
        logic [7:0]  ops [5] = '{8'hF1, 8'hF1, 8'hF2, 8'hF2, 8'hF0};
        logic        zs  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [14:0] ex  [5] = '{PSRC | RIMM | PCEN, RIMM | PCEN, PSRC | RIMM | PCEN,
                                 RIMM | PCEN, PSRC | RIMM | PCEN};
        for (int i = 0; i < 5; i++) begin
            step(0, 1, ops[i], 0, 0);
            step(0, 1, 8'h20 + 8'(i), 0, 0);
            step(0, 0, 8'h00, 0, zs[i]);
            vectors++;
            if ({ctl, alu_op, imm} !== {ex[i], 3'd5, 8'h20 + 8'(i)}) begin
                miscompares++;
                $display("FAIL br_exec[%0d] ctl=%h alu=%0d imm=%h exp ctl=%h alu=5", i, ctl, alu_op, imm, ex[i]);
            end
        end
    endtask

    task automatic test_load_store();
        step(0, 1, 8'h78, 0, 0);
        step(0, 1, 8'h40, 0, 0); e = IREQ | ISEL;
        vectors++; if (ctl !== e) begin miscompares++; $display("FAIL ld_fetch_imm ctl=%h exp=%h", ctl, e); end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 8'h00, 0, 0); e = DREQ;
            vectors++; if (ctl !== e) begin miscompares++; $display("FAIL ld_wait[%0d] ctl=%h exp=%h", i, ctl, e); end
        end
        step(0, 0, 8'h00, 1, 0); e = DREQ | RWR | M2R | RIMM | PCEN;
        vectors++; if (ctl !== e) begin miscompares++; $display("FAIL ld_ack ctl=%h exp=%h", ctl, e); end
        step(0, 0, 8'h00, 0, 0); e = IREQ;
        vectors++; if (ctl !== e) begin miscompares++; $display("FAIL ld_refetch ctl=%h exp=%h", ctl, e); end
        step(0, 0, 8'h00, 1, 0); e = IREQ;
        vectors++; if (ctl !== e) begin miscompares++; $display("FAIL stray_dack ctl=%h exp=%h", ctl, e); end
        step(0, 1, 8'h71, 0, 0);
        step(0, 1, 8'h41, 0, 0);
        step(0, 0, 8'h00, 1, 0); e = DREQ | DWE | RIMM | PCEN;
        vectors++; if (ctl !== e) begin miscompares++; $display("FAIL st_ack ctl=%h exp=%h", ctl, e); end
    endtask

    task automatic test_illegal_nop();
        step(0, 1, 8'h80, 0, 0);
        step(0, 0, 8'h00, 0, 0); e = ILL | PCEN;
        vectors++; if (ctl !== e) begin miscompares++; $display("FAIL ill8 ctl=%h exp=%h", ctl, e); end
        step(0, 1, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 0); e = PCEN;
        vectors++; if (ctl !== e) begin miscompares++; $display("FAIL nop ctl=%h exp=%h", ctl, e); end
    endtask

    task automatic test_stack();
`ifdef SEQ_STACK_EN
        step(0, 1, 8'h72, 0, 0);
        step(0, 0, 8'h00, 1, 0); e = DREQ | DWE | SPWR | PCEN;
        vectors++;
        if ({ctl, alu_ex} !== {e, ALU_EX_SP_DEC}) begin
            miscompares++; $display("FAIL push ctl=%h ex=%0d exp=%h ex=1", ctl, alu_ex, e);
        end
        step(0, 1, 8'h73, 0, 0);
        step(0, 0, 8'h00, 1, 0); e = DREQ | RWR | M2R | SPWR | MSP | PCEN;
        vectors++;
        if ({ctl, alu_ex} !== {e, ALU_EX_SP_INC}) begin
            miscompares++; $display("FAIL pop ctl=%h ex=%0d exp=%h ex=2", ctl, alu_ex, e);
        end
`else
        step(0, 1, 8'h72, 0, 0);
        step(0, 0, 8'h00, 1, 0); e = ILL | PCEN;
        vectors++; if (ctl !== e) begin miscompares++; $display("FAIL push_ill ctl=%h exp=%h", ctl, e); end
        step(0, 1, 8'h73, 0, 0);
        step(0, 0, 8'h00, 1, 0); e = ILL | PCEN;
        vectors++; if (ctl !== e) begin miscompares++; $display("FAIL pop_ill ctl=%h exp=%h", ctl, e); end
`endif
    endtask

    task automatic test_timeout();
        step(0, 1, 8'h74, 0, 0);
        step(0, 1, 8'h50, 0, 0);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 8'h00, 0, 0); e = (i == 15) ? (DREQ | BERR | RIMM | PCEN) : DREQ;
            vectors++; if (ctl !== e) begin miscompares++; $display("FAIL to_mem[%0d] ctl=%h exp=%h", i, ctl, e); end
        end
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 8'h00, 0, 0); e = (i == 15) ? (IREQ | BERR | PCEN) : IREQ;
            vectors++; if (ctl !== e) begin miscompares++; $display("FAIL to_fetch[%0d] ctl=%h exp=%h", i, ctl, e); end
        end
        step(0, 0, 8'h00, 0, 0); e = IREQ;
        vectors++; if (ctl !== e) begin miscompares++; $display("FAIL to_after ctl=%h exp=%h", ctl, e); end
    endtask

    task automatic test_reset_mid_halt();
        step(0, 1, 8'h78, 0, 0);
        step(0, 1, 8'h40, 0, 0);
        step(0, 0, 8'h00, 0, 0); e = DREQ;
        vectors++; if (ctl !== e) begin miscompares++; $display("FAIL rm_mem ctl=%h exp=%h", ctl, e); end
        step(1, 0, 8'h00, 0, 0); e = '0;
        vectors++; if (ctl !== e) begin miscompares++; $display("FAIL rm_rst ctl=%h exp=%h", ctl, e); end
        step(0, 1, 8'hFF, 0, 0); e = IREQ;
        vectors++; if (ctl !== e) begin miscompares++; $display("FAIL rm_refetch ctl=%h exp=%h", ctl, e); end
        step(0, 0, 8'h00, 0, 0); e = '0;
        vectors++; if (ctl !== e) begin miscompares++; $display("FAIL halt_exec ctl=%h exp=%h", ctl, e); end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 8'h16, 1, 0); e = HLT;
            vectors++; if (ctl !== e) begin miscompares++; $display("FAIL halt_hold[%0d] ctl=%h exp=%h", i, ctl, e); end
        end
        step(1, 0, 8'h00, 0, 0); e = '0;
        vectors++; if (ctl !== e) begin miscompares++; $display("FAIL halt_rst ctl=%h exp=%h", ctl, e); end
        step(0, 0, 8'h00, 0, 0); e = IREQ;
        vectors++; if (ctl !== e) begin miscompares++; $display("FAIL halt_exit ctl=%h exp=%h", ctl, e); end
    endtask

    initial begin
        bus.imem_ack  = 1'b0;
        bus.imem_data = 8'h00;
        bus.dmem_ack  = 1'b0;
        test_reset();
        test_reg_reg();
        test_imm_alu();
        test_branch();
        test_load_store();
        test_illegal_nop();
        test_stack();
        test_timeout();
        test_reset_mid_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
